// File: rtl/uart_tx_sched.sv
// Byte scheduler in front of a UART transmitter: one request slot per source
// (RF byte, ALU 16-bit word), round-robin arbitration, strobe retry and ALU LSB/MSB sequencing.
module uart_tx_sched #(
   parameter int unsigned BUSY_WAIT_MAX = 4
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [7:0]  RF_RD_DATA,
   input  logic        RF_RD_VLD,
   input  logic [15:0] ALU_OUT,
   input  logic        ALU_OUT_VLD,
   input  logic        TX_BUSY,
   output logic [7:0]  TX_P_DATA,
   output logic        TX_DATA_VALID,
   output logic        DROP,
   output logic        SCHED_BUSY
);

   localparam logic [3:0] WAIT_MAX = 4'(BUSY_WAIT_MAX);

   typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_DONE} state_t;

   state_t      state_q, state_d;
   logic        rf_pend_q, rf_pend_d;
   logic [7:0]  rf_data_q, rf_data_d;
   logic        alu_pend_q, alu_pend_d;
   logic [15:0] alu_data_q, alu_data_d;
   logic [7:0]  msb_q, msb_d;
   logic        msb_due_q, msb_due_d;
   logic        last_alu_q, last_alu_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [7:0]  p_data_q, p_data_d;
   logic        dv_q, dv_d;
   logic        drop_q, drop_d;
   logic        sbusy_q, sbusy_d;
   logic        grant_rf, grant_alu;

   // The priority pointer only moves when a tie is actually arbitrated.
   always_comb begin
      grant_rf  = 1'b0;
      grant_alu = 1'b0;
      if (state_q == IDLE && !TX_BUSY) begin
         if (rf_pend_q && alu_pend_q) begin
            grant_rf  = last_alu_q;
            grant_alu = !last_alu_q;
         end else begin
            grant_rf  = rf_pend_q;
            grant_alu = alu_pend_q;
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      p_data_d   = p_data_q;
      dv_d       = 1'b0;
      drop_d     = 1'b0;
      msb_d      = msb_q;
      msb_due_d  = msb_due_q;
      last_alu_d = last_alu_q;
      rf_pend_d  = rf_pend_q && !grant_rf;
      rf_data_d  = rf_data_q;
      alu_pend_d = alu_pend_q && !grant_alu;
      alu_data_d = alu_data_q;

      // A slot freed by a grant on this edge can take a new request at once.
      if (RF_RD_VLD) begin
         if (!rf_pend_q || grant_rf) begin
            rf_data_d = RF_RD_DATA;
            rf_pend_d = 1'b1;
         end else begin
            drop_d = 1'b1;
         end
      end
      if (ALU_OUT_VLD) begin
         if (!alu_pend_q || grant_alu) begin
            alu_data_d = ALU_OUT;
            alu_pend_d = 1'b1;
         end else begin
            drop_d = 1'b1;
         end
      end

      case (state_q)
         IDLE: begin
            if (grant_rf || grant_alu) begin
               p_data_d  = grant_alu ? alu_data_q[7:0] : rf_data_q;
               dv_d      = 1'b1;
               cnt_d     = 4'd0;
               msb_due_d = grant_alu;
               state_d   = WAIT_ACK;
               if (grant_alu) msb_d = alu_data_q[15:8];
               if (rf_pend_q && alu_pend_q) last_alu_d = grant_alu;
            end
         end
         WAIT_ACK: begin
            if (TX_BUSY) begin
               state_d = WAIT_DONE;
            end else if (cnt_q == WAIT_MAX) begin
               dv_d  = 1'b1;
               cnt_d = 4'd0;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         WAIT_DONE: begin
            if (!TX_BUSY) begin
               if (msb_due_q) begin
                  p_data_d  = msb_q;
                  dv_d      = 1'b1;
                  cnt_d     = 4'd0;
                  msb_due_d = 1'b0;
                  state_d   = WAIT_ACK;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      sbusy_d = (state_d != IDLE) || rf_pend_d || alu_pend_d;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q    <= IDLE;
         rf_pend_q  <= 1'b0;
         alu_pend_q <= 1'b0;
         msb_due_q  <= 1'b0;
         last_alu_q <= 1'b1;
         cnt_q      <= 4'd0;
         p_data_q   <= 8'h00;
         dv_q       <= 1'b0;
         drop_q     <= 1'b0;
         sbusy_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         rf_pend_q  <= rf_pend_d;
         alu_pend_q <= alu_pend_d;
         msb_due_q  <= msb_due_d;
         last_alu_q <= last_alu_d;
         cnt_q      <= cnt_d;
         p_data_q   <= p_data_d;
         dv_q       <= dv_d;
         drop_q     <= drop_d;
         sbusy_q    <= sbusy_d;
      end
   end

   // Slot payloads are only meaningful while their pending flag is set.
   always_ff @(posedge CLK) begin
      rf_data_q  <= rf_data_d;
      alu_data_q <= alu_data_d;
      msb_q      <= msb_d;
   end

   assign TX_P_DATA     = p_data_q;
   assign TX_DATA_VALID = dv_q;
   assign DROP          = drop_q;
   assign SCHED_BUSY    = sbusy_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Scoreboard bench for uart_tx_sched: directed requests push expected bytes,
// a monitor pops and compares on every TX_DATA_VALID strobe.
module tb_uart_tx_sched;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic [7:0]  RF_RD_DATA = 8'h00;
   logic        RF_RD_VLD = 1'b0;
   logic [15:0] ALU_OUT = 16'h0000;
   logic        ALU_OUT_VLD = 1'b0;
   logic        TX_BUSY = 1'b0;
   logic [7:0]  TX_P_DATA;
   logic        TX_DATA_VALID;
   logic        DROP;
   logic        SCHED_BUSY;

   typedef struct packed {
      logic [7:0] data;
      logic       need_busy;
   } exp_t;

   exp_t exp_q[$];
   exp_t e;
   int   errors = 0;
   int   checks = 0;
   int   strobe_cnt = 0;
   int   drop_cnt = 0;
   int   cyc = 0;
   int   last_strobe_cyc = 0;
   int   last_gap = 0;
   int   s0;
   bit   busy_hi_seen = 1'b0;
   bit   model_en = 1'b1;
   bit   force_busy = 1'b0;
   bit   start_pend = 1'b0;
   int   busy_cnt = 0;

   uart_tx_sched #(.BUSY_WAIT_MAX(4)) dut (
      .CLK          (CLK),
      .RST          (RST),
      .RF_RD_DATA   (RF_RD_DATA),
      .RF_RD_VLD    (RF_RD_VLD),
      .ALU_OUT      (ALU_OUT),
      .ALU_OUT_VLD  (ALU_OUT_VLD),
      .TX_BUSY      (TX_BUSY),
      .TX_P_DATA    (TX_P_DATA),
      .TX_DATA_VALID(TX_DATA_VALID),
      .DROP         (DROP),
      .SCHED_BUSY   (SCHED_BUSY)
   );

   initial forever #5 CLK = ~CLK;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic push_exp(input logic [7:0] d, input logic nb);
      exp_t x;
      x.data      = d;
      x.need_busy = nb;
      exp_q.push_back(x);
   endtask

   task automatic pulse_rf(input logic [7:0] d);
      RF_RD_DATA = d;
      RF_RD_VLD  = 1'b1;
      step();
      RF_RD_VLD  = 1'b0;
   endtask

   task automatic pulse_alu(input logic [15:0] d);
      ALU_OUT     = d;
      ALU_OUT_VLD = 1'b1;
      step();
      ALU_OUT_VLD = 1'b0;
   endtask

   task automatic pulse_both(input logic [7:0] r, input logic [15:0] a);
      RF_RD_DATA  = r;
      ALU_OUT     = a;
      RF_RD_VLD   = 1'b1;
      ALU_OUT_VLD = 1'b1;
      step();
      RF_RD_VLD   = 1'b0;
      ALU_OUT_VLD = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n;
      n = 0;
      while (!(exp_q.size() == 0 && !SCHED_BUSY && !TX_BUSY) && n < 400) begin
         step();
         n++;
      end
      check(name, int'(n < 400), 1);
   endtask

   task automatic wait_strobes(input string name, input int target);
      int n;
      n = 0;
      while (strobe_cnt < target && n < 400) begin
         step();
         n++;
      end
      check(name, int'(n < 400), 1);
   endtask

   // Transmitter model: busy rises one cycle after an accepted strobe and lasts 10 cycles.
   always @(posedge CLK) begin
      #2;
      if (start_pend) begin
         busy_cnt   = 10;
         start_pend = 1'b0;
      end else if (busy_cnt > 0) begin
         busy_cnt--;
      end
      if (TX_DATA_VALID && model_en && busy_cnt == 0) start_pend = 1'b1;
      TX_BUSY = force_busy || (busy_cnt > 0);
   end

   always @(negedge CLK) begin
      cyc++;
      if (DROP) drop_cnt++;
      if (TX_DATA_VALID) begin
         strobe_cnt++;
         last_gap        = cyc - last_strobe_cyc;
         last_strobe_cyc = cyc;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_strobe: got data 0x%0h, expected no strobe", TX_P_DATA);
         end else begin
            e = exp_q.pop_front();
            check("strobe_data", int'(TX_P_DATA), int'(e.data));
            if (e.need_busy) check("msb_after_busy_fall", int'(busy_hi_seen), 1);
         end
         busy_hi_seen = 1'b0;
      end
      if (TX_BUSY) busy_hi_seen = 1'b1;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset, with a request that must be ignored
      step();
      step();
      RF_RD_DATA = 8'h77;
      RF_RD_VLD  = 1'b1;
      step();
      RF_RD_VLD  = 1'b0;
      @(negedge CLK);
      check("rst_pdata", int'(TX_P_DATA), 'h00);
      check("rst_dv", int'(TX_DATA_VALID), 0);
      check("rst_drop", int'(DROP), 0);
      check("rst_sbusy", int'(SCHED_BUSY), 0);
      step();
      RST = 1'b0;
      repeat (4) step();
      check("rst_req_ignored_sbusy", int'(SCHED_BUSY), 0);
      check("rst_req_ignored_strobes", strobe_cnt, 0);

      // Single RF byte with latency check
      s0 = strobe_cnt;
      push_exp(8'hA5, 1'b0);
      pulse_rf(8'hA5);
      @(negedge CLK);
      check("rf_latency_cycle1_dv", int'(TX_DATA_VALID), 0);
      check("rf_pending_sbusy", int'(SCHED_BUSY), 1);
      @(negedge CLK);
      check("rf_latency_cycle2_dv", int'(TX_DATA_VALID), 1);
      step();
      wait_idle("rf_idle_timeout");
      check("rf_strobe_count", strobe_cnt - s0, 1);
      check("rf_idle_sbusy", int'(SCHED_BUSY), 0);
      check("rf_pdata_hold", int'(TX_P_DATA), 'hA5);

      // ALU word: LSB then MSB
      s0 = strobe_cnt;
      push_exp(8'h34, 1'b0);
      push_exp(8'h12, 1'b1);
      pulse_alu(16'h1234);
      wait_idle("alu_idle_timeout");
      check("alu_strobe_count", strobe_cnt - s0, 2);
      check("alu_pdata_hold", int'(TX_P_DATA), 'h12);

      // Round-robin ties starting from reset
      RST = 1'b1;
      step();
      RST = 1'b0;
      s0 = strobe_cnt;
      push_exp(8'h11, 1'b0);
      push_exp(8'hEF, 1'b0);
      push_exp(8'hBE, 1'b1);
      pulse_both(8'h11, 16'hBEEF);
      wait_idle("rr1_idle_timeout");
      push_exp(8'hEF, 1'b0);
      push_exp(8'hBE, 1'b1);
      push_exp(8'h11, 1'b0);
      pulse_both(8'h11, 16'hBEEF);
      wait_idle("rr2_idle_timeout");
      check("rr_strobe_count", strobe_cnt - s0, 6);

      // Busy held: second RF request dropped, then a request on the grant edge is kept
      force_busy = 1'b1;
      step();
      step();
      s0 = strobe_cnt;
      push_exp(8'h01, 1'b0);
      push_exp(8'h03, 1'b1);
      pulse_rf(8'h01);
      @(negedge CLK);
      check("drop_first_req", int'(DROP), 0);
      step();
      pulse_rf(8'h02);
      @(negedge CLK);
      check("drop_pulse", int'(DROP), 1);
      @(negedge CLK);
      check("drop_one_cycle", int'(DROP), 0);
      check("busy_hold_no_strobe", strobe_cnt - s0, 0);
      check("busy_hold_sbusy", int'(SCHED_BUSY), 1);
      step();
      force_busy = 1'b0;
      RF_RD_DATA = 8'h03;
      RF_RD_VLD  = 1'b1;
      step();
      RF_RD_VLD  = 1'b0;
      @(negedge CLK);
      check("grant_edge_no_drop", int'(DROP), 0);
      check("grant_edge_dv", int'(TX_DATA_VALID), 1);
      step();
      wait_idle("drop_idle_timeout");
      check("drop_strobe_count", strobe_cnt - s0, 2);

      // No busy ever: retry every BUSY_WAIT_MAX+1 cycles, then reset
      model_en = 1'b0;
      s0 = strobe_cnt;
      repeat (4) push_exp(8'h5A, 1'b0);
      pulse_rf(8'h5A);
      wait_strobes("retry_timeout", s0 + 4);
      check("retry_period", last_gap, 5);
      check("retry_pdata", int'(TX_P_DATA), 'h5A);
      RST = 1'b1;
      step();
      @(negedge CLK);
      check("retry_rst_dv", int'(TX_DATA_VALID), 0);
      check("retry_rst_pdata", int'(TX_P_DATA), 'h00);
      check("retry_rst_sbusy", int'(SCHED_BUSY), 0);
      step();
      RST = 1'b0;
      model_en = 1'b1;
      repeat (12) step();

      // Reset while waiting for the LSB to finish: MSB must never go out
      s0 = strobe_cnt;
      push_exp(8'hFE, 1'b0);
      pulse_alu(16'hCAFE);
      begin
         int n;
         n = 0;
         while (!TX_BUSY && n < 50) begin
            step();
            n++;
         end
         check("midxfer_busy_timeout", int'(n < 50), 1);
      end
      repeat (3) step();
      RST         = 1'b1;
      ALU_OUT     = 16'h1111;
      ALU_OUT_VLD = 1'b1;
      step();
      ALU_OUT_VLD = 1'b0;
      @(negedge CLK);
      check("midxfer_rst_dv", int'(TX_DATA_VALID), 0);
      check("midxfer_rst_pdata", int'(TX_P_DATA), 'h00);
      check("midxfer_rst_sbusy", int'(SCHED_BUSY), 0);
      check("midxfer_rst_drop", int'(DROP), 0);
      step();
      RST = 1'b0;
      repeat (20) step();
      check("midxfer_msb_suppressed", strobe_cnt - s0, 1);
      check("midxfer_idle_sbusy", int'(SCHED_BUSY), 0);

      check("total_drops", drop_cnt, 1);
      check("queue_empty", exp_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/uart_tx_sched.md
UART_TX_SCHED -- requirements
Module: uart_tx_sched

Interface
REQ-001 SHALL have parameter: BUSY_WAIT_MAX, default 4 (legal 2..15), cycles to wait for TX_BUSY rise before re-pulsing TX_DATA_VALID.
REQ-002 SHALL have port: CLK  in  1  single clock; all logic on rising edge.
REQ-003 SHALL have port: RST  in  1  reset; synchronous, active-high.
REQ-004 SHALL have port: RF_RD_DATA  in  8  register-file read byte.
REQ-005 SHALL have port: RF_RD_VLD  in  1  one-cycle request pulse qualifying RF_RD_DATA.
REQ-006 SHALL have port: ALU_OUT  in  16  ALU result, sent LSB byte then MSB byte.
REQ-007 SHALL have port: ALU_OUT_VLD  in  1  one-cycle request pulse qualifying ALU_OUT.
REQ-008 SHALL have port: TX_BUSY  in  1  busy flag from UART transmitter.
REQ-009 SHALL have port: TX_P_DATA  out  8  byte presented to the transmitter P_DATA.
REQ-010 SHALL have port: TX_DATA_VALID  out  1  one-cycle load strobe to the transmitter DATA_VALID.
REQ-011 SHALL have port: DROP  out  1  one-cycle pulse when a request is discarded (slot full).
REQ-012 SHALL have port: SCHED_BUSY  out  1  high when any slot pending or FSM not IDLE.

Function
REQ-013 SHALL hold one slot per source (RF: 8-bit data + pending flag; ALU: 16-bit data + pending flag), capturing data and setting pending on the edge the VLD pulse is sampled.
REQ-014 SHALL, when VLD arrives while that slot is pending and not granted on the same edge, keep old data, discard new, and pulse DROP the following cycle.
REQ-015 SHALL, when VLD arrives on the same edge its slot is granted, accept the new request into the freed slot (no DROP).
REQ-016 SHALL implement FSM states IDLE, WAIT_ACK, WAIT_DONE; all outputs registered.
REQ-017 SHALL, in IDLE with any slot pending and TX_BUSY=0, grant on that edge: load TX_P_DATA with the byte (RF data or ALU[7:0]), set TX_DATA_VALID=1, clear the granted pending flag, copy ALU[15:8] to an internal MSB register if ALU granted, clear wait counter, go to WAIT_ACK.
REQ-018 SHALL stay in IDLE while TX_BUSY=1, regardless of pending slots.
REQ-019 SHALL hold TX_DATA_VALID high exactly one cycle per load; TX_P_DATA stable from load until next load.
REQ-020 SHALL arbitrate round-robin when both slots pending: grant the source not granted last; last-grant reset value = ALU (RF wins first tie after reset).
REQ-021 SHALL, in WAIT_ACK, go to WAIT_DONE on the edge TX_BUSY=1 is sampled; else increment wait counter (4 bits).
REQ-022 SHALL, in WAIT_ACK with counter == BUSY_WAIT_MAX and TX_BUSY=0, re-assert TX_DATA_VALID one cycle with same TX_P_DATA and clear counter (retry period BUSY_WAIT_MAX+1 cycles); unlimited retries.
REQ-023 SHALL, in WAIT_DONE on sampling TX_BUSY=0: if ALU LSB just sent, load TX_P_DATA=MSB register, pulse TX_DATA_VALID, clear counter, go WAIT_ACK; otherwise go IDLE.
REQ-024 SHALL never interleave bytes of another request between ALU LSB and MSB.
REQ-025 SHALL give latency: VLD sampled at edge N with FSM IDLE and TX_BUSY=0 -> TX_DATA_VALID high in the cycle after edge N+1.
REQ-026 SHALL drive SCHED_BUSY = (state != IDLE) OR RF pending OR ALU pending, registered.

Reset
REQ-027 SHALL, on RST sampled high (any state, incl. mid-transfer), set state IDLE, both pending flags 0, TX_P_DATA 0x00, TX_DATA_VALID 0, DROP 0, SCHED_BUSY 0, counter 0, last-grant ALU; requests sampled with RST high are ignored.

Verification
REQ-028 SHALL cover: RF_RD_VLD with 0xA5, transmitter model raises TX_BUSY 1 cycle after strobe for 10 cycles -> single TX_DATA_VALID, TX_P_DATA=0xA5, return to IDLE, SCHED_BUSY low.
REQ-029 SHALL cover: ALU_OUT_VLD with 0x1234 -> strobes with 0x34 then 0x12, second only after TX_BUSY falls.
REQ-030 SHALL cover: RF 0x11 and ALU 0xBEEF same cycle after reset -> bytes 0x11, 0xEF, 0xBE; repeat both -> 0xEF, 0xBE, 0x11.
REQ-031 SHALL cover: TX_BUSY held high, two RF pulses (0x01, 0x02) -> DROP one cycle after second, only 0x01 sent after TX_BUSY drops.
REQ-032 SHALL cover: TX_BUSY never rises after strobe -> TX_DATA_VALID re-pulses every 5 cycles (default), same data.
REQ-033 SHALL cover: RST during WAIT_DONE of ALU LSB -> outputs reset next cycle, MSB never sent, pending cleared.
